// File: rtl/pwm_demod_pkg.sv
// Shared types and helpers for the PWM period/high-time demodulator.
package pwm_demod_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  // Largest count a WIDTH-bit cycle counter may reach before a period is declared lost.
  function automatic int max_cnt(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/pwm_demod_sync_rise_det.sv
// Two-flop synchronizer for the asynchronous PWM input plus an edge flop
// producing a single-cycle rising-edge pulse in the clk domain.
module sync_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/pwm_demod.sv
// Measures an incoming PWM train: period (rise to rise) and high time in clk
// cycles, with a one-cycle valid per period and a timeout when edges stop.
module pwm_demod
  import pwm_demod_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam int               MAX_I   = max_cnt(WIDTH);
  localparam logic [WIDTH-1:0] CNT_MAX = MAX_I[WIDTH-1:0];
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic level;
  logic rise;

  sync_rise_det u_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (pwm_in),
    .level (level),
    .rise  (rise)
  );

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] pcnt;
  logic [WIDTH-1:0] pcnt_n;
  logic [WIDTH-1:0] hcnt;
  logic [WIDTH-1:0] hcnt_n;
  logic [WIDTH-1:0] period_n;
  logic [WIDTH-1:0] high_n;
  logic             valid_n;
  logic             timeout_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pcnt      <= '0;
      hcnt      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      pcnt      <= pcnt_n;
      hcnt      <= hcnt_n;
      period    <= period_n;
      high_time <= high_n;
      valid     <= valid_n;
      timeout   <= timeout_n;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    pcnt_n    = pcnt;
    hcnt_n    = hcnt;
    period_n  = period;
    high_n    = high_time;
    valid_n   = 1'b0;
    timeout_n = 1'b0;

    case (state)
      IDLE: begin
        pcnt_n = '0;
        hcnt_n = '0;
        if (rise && en) begin
          state_n = MEASURE;
          pcnt_n  = CNT_ONE;
          hcnt_n  = CNT_ONE;
        end
      end

      MEASURE: begin
        if (!en) begin
          state_n = IDLE;
          pcnt_n  = '0;
          hcnt_n  = '0;
        end else if (rise) begin
          // A rise on the final count still closes a valid period, so it wins over timeout.
          period_n = pcnt;
          high_n   = hcnt;
          valid_n  = 1'b1;
          pcnt_n   = CNT_ONE;
          hcnt_n   = CNT_ONE;
        end else if (pcnt == CNT_MAX) begin
          state_n   = IDLE;
          timeout_n = 1'b1;
          pcnt_n    = '0;
          hcnt_n    = '0;
        end else begin
          pcnt_n = pcnt + CNT_ONE;
          hcnt_n = hcnt + WIDTH'(level);
        end
      end

      default: begin
        state_n = IDLE;
        pcnt_n  = '0;
        hcnt_n  = '0;
      end
    endcase
  end

  assign busy = (state == MEASURE);

endmodule
